pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the stall and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three sources: load-use hazards, taken branches/jumps resolved in EX, and data-memory wait states in MEM. A small FSM does three things:
- guarantees exactly one bubble per load-use;
- freezes the pipe while memory is not ready;
- flags memory accesses that never complete.

Parameters:
WAIT_W, 8, width of the memory-wait cycle counter
MAX_WAIT, 200, wait cycles in MEM_WAIT after which timeout_err_o is set (must be < 2**WAIT_W)
CNT_W, 32, width of the performance counters (only used with HAZARD_PERF_CNT_EN)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1_addr_i  in  5  rs1 of the instruction in ID
id_rs2_addr_i  in  5  rs2 of the instruction in ID
id_uses_rs1_i  in  1  ID instruction reads rs1
id_uses_rs2_i  in  1  ID instruction reads rs2
ex_rd_addr_i  in  5  rd of the instruction in EX
ex_mem_read_i  in  1  EX instruction is a load
ex_branch_taken_i  in  1  EX redirects the PC (taken branch, JAL, JALR)
mem_req_i  in  1  MEM instruction accesses data memory
dmem_ready_i  in  1  data memory completes the access this cycle
flush_all_i  in  1  trap/exception: kill all in-flight instructions
pc_stall_o  out  1  hold PC
if_id_stall_o  out  1  hold IF/ID
if_id_flush_o  out  1  clear IF/ID
id_ex_stall_o  out  1  hold ID/EX
id_ex_flush_o  out  1  clear ID/EX (inject NOP)
ex_mem_stall_o  out  1  hold EX/MEM
ex_mem_flush_o  out  1  clear EX/MEM
mem_wb_flush_o  out  1  clear MEM/WB (bubble into WB)
state_o  out  2  FSM state: 00 RUN, 01 LU_BUBBLE, 10 MEM_WAIT
timeout_err_o  out  1  sticky memory-timeout flag

Behaviour:
- One clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state RUN, wait counter 0, timeout_err_o 0, perf counters 0. While rst_n is low, all stall/flush outputs are forced to 0.
- Stall/flush outputs are combinational from the current state and inputs (zero latency). State, counters and error flag are registered.
- Derived terms:
  - mem_busy = mem_req_i & ~dmem_ready_i
  - lu_haz = ex_mem_read_i & (ex_rd_addr_i != 0) & ((id_uses_rs1_i & id_rs1_addr_i == ex_rd_addr_i) | (id_uses_rs2_i & id_rs2_addr_i == ex_rd_addr_i))
- Output priority, highest first:
  1. flush_all_i: all flush outputs = 1, all stalls = 0. Next state RUN, wait counter cleared. Does not clear timeout_err_o.
  2. mem_busy: pc/if_id/id_ex/ex_mem stalls = 1, mem_wb_flush_o = 1, all other flushes = 0. A simultaneous ex_branch_taken_i or lu_haz is deferred, because EX is frozen and re-presents it.
  3. ex_branch_taken_i: if_id_flush_o = 1 and id_ex_flush_o = 1; no stalls (PC loads the target). lu_haz is ignored because the ID instruction is killed.
  4. lu_haz, evaluated only in state RUN: pc_stall_o = 1, if_id_stall_o = 1, id_ex_flush_o = 1.
  5. Otherwise: all outputs 0.
- FSM transitions:
  - RUN: mem_busy -> MEM_WAIT; else lu_haz (taking priority 4) -> LU_BUBBLE; else stay.
  - LU_BUBBLE: lasts exactly one cycle; lu_haz is masked here. mem_busy -> MEM_WAIT; else -> RUN.
  - MEM_WAIT: mem_busy -> stay; else -> RUN.
- Wait counter:
  - Increments every cycle mem_busy is 1 (saturating at 2**WAIT_W-1).
  - Clears on any cycle mem_busy is 0.
  - When it reaches MAX_WAIT while mem_busy: timeout_err_o is set and held until reset. The pipeline keeps stalling; no auto-release.
- Waiting ends the same cycle dmem_ready_i rises: stalls drop combinationally in that cycle.
- Reset asserted mid-MEM_WAIT: immediately RUN, counter 0, outputs 0.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs perf_lu_cnt_o, perf_wait_cnt_o and perf_flush_cnt_o, each CNT_W bits, wrapping modulo 2**CNT_W, reset to 0.
  - perf_lu_cnt_o: count of load-use bubbles.
  - perf_wait_cnt_o: count of mem_busy cycles.
  - perf_flush_cnt_o: count of cycles with a branch flush or flush_all_i.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Load-use: EX = lw x5 (ex_mem_read_i = 1, rd = 5), ID reads rs1 = x5 -> that cycle pc_stall_o = if_id_stall_o = id_ex_flush_o = 1, state_o = 01 next cycle, then 00. Repeat with rd = x0 -> no stall.
- Branch: ex_branch_taken_i = 1 with lu_haz also true -> if_id_flush_o = id_ex_flush_o = 1, pc_stall_o = 0, next state stays 00.
- Memory wait: mem_req_i = 1, dmem_ready_i = 0 for 3 cycles then 1 -> stalls plus mem_wb_flush_o high for exactly 3 cycles, state_o = 10 during cycles 2-3, back to 00 after ready; a branch held in EX is flushed only in the ready cycle.
- Timeout: MAX_WAIT = 4, dmem_ready_i held 0 -> timeout_err_o = 1 after the 4th busy cycle, stays 1 after ready arrives and after flush_all_i; cleared only by rst_n.
- Trap priority: flush_all_i = 1 together with mem_busy and lu_haz -> all four flushes = 1, no stalls, state 00 next cycle.
- Reset mid-wait: rst_n low during MEM_WAIT with counter = 2 -> outputs immediately 0, state_o = 00, counter and perf counters 0 (with HAZARD_PERF_CNT_EN).

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use bubble, EX redirect, MEM wait freeze, memory timeout.
// Controls are combinational (zero latency); optional perf counters under HAZARD_PERF_CNT_EN.
`timescale 1ns/1ps
module pipeline_hazard_ctrl #(
  parameter int unsigned WAIT_W   = 8,
  parameter int unsigned MAX_WAIT = 200
`ifdef HAZARD_PERF_CNT_EN
  , parameter int unsigned CNT_W  = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             dmem_ready_i,
  input  logic             flush_all_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_stall_o,
  output logic             ex_mem_flush_o,
  output logic             mem_wb_flush_o,
  output logic [1:0]       state_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] perf_lu_cnt_o,
  output logic [CNT_W-1:0] perf_wait_cnt_o,
  output logic [CNT_W-1:0] perf_flush_cnt_o,
`endif
  output logic             timeout_err_o
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_LU_BUBBLE = 2'b01,
    ST_MEM_WAIT  = 2'b10
  } state_e;

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic              mem_busy, lu_haz, rs1_hit, rs2_hit;
  logic              lu_take, br_take;

  always_comb begin
    rs1_hit  = id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
    rs2_hit  = id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);
    lu_haz   = ex_mem_read_i && (ex_rd_addr_i != 5'd0) && (rs1_hit || rs2_hit);
    mem_busy = mem_req_i && !dmem_ready_i;
  end

  // Priority chain: trap > memory freeze > EX redirect > load-use (RUN only).
  always_comb begin
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    ex_mem_flush_o = 1'b0;
    mem_wb_flush_o = 1'b0;
    lu_take        = 1'b0;
    br_take        = 1'b0;
    state_d        = ST_RUN;
    if (!rst_n) begin
      state_d = ST_RUN;
    end else if (flush_all_i) begin
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
      mem_wb_flush_o = 1'b1;
    end else if (mem_busy) begin
      pc_stall_o     = 1'b1;
      if_id_stall_o  = 1'b1;
      id_ex_stall_o  = 1'b1;
      ex_mem_stall_o = 1'b1;
      mem_wb_flush_o = 1'b1;
      state_d        = ST_MEM_WAIT;
    end else if (ex_branch_taken_i) begin
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      br_take        = 1'b1;
    end else if (state_q == ST_RUN && lu_haz) begin
      pc_stall_o     = 1'b1;
      if_id_stall_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      lu_take        = 1'b1;
      state_d        = ST_LU_BUBBLE;
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    timeout_d  = timeout_q;
    if (!flush_all_i && mem_busy) begin
      wait_cnt_d = (wait_cnt_q == {WAIT_W{1'b1}}) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
      if (wait_cnt_d >= MAX_WAIT_C) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign state_o       = state_q;
  assign timeout_err_o = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_lu_q, perf_lu_d;
  logic [CNT_W-1:0] perf_wait_q, perf_wait_d;
  logic [CNT_W-1:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_lu_d    = perf_lu_q + CNT_W'(lu_take);
    perf_wait_d  = perf_wait_q + CNT_W'(mem_busy);
    perf_flush_d = perf_flush_q + CNT_W'(br_take || flush_all_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_q    <= '0;
      perf_wait_q  <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_lu_q    <= perf_lu_d;
      perf_wait_q  <= perf_wait_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_lu_cnt_o    = perf_lu_q;
  assign perf_wait_cnt_o  = perf_wait_q;
  assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized run against a rule-level model.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam int MAX_WAIT = 4;

  // Control vector order: pc_stall, if_id_stall, if_id_flush, id_ex_stall,
  // id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_flush
  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_TRAP  = 8'b0010_1011;
  localparam logic [7:0] C_FREEZ = 8'b1101_0101;
  localparam logic [7:0] C_BR    = 8'b0010_1000;
  localparam logic [7:0] C_LU    = 8'b1100_1000;

  logic       clk, rst_n;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic       id_uses_rs1_i, id_uses_rs2_i, ex_mem_read_i, ex_branch_taken_i;
  logic       mem_req_i, dmem_ready_i, flush_all_i;
  logic       pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o;
  logic       id_ex_flush_o, ex_mem_stall_o, ex_mem_flush_o, mem_wb_flush_o;
  logic [1:0] state_o;
  logic       timeout_err_o;
  logic [7:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(.WAIT_W(8), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_mem_read_i(ex_mem_read_i),
    .ex_branch_taken_i(ex_branch_taken_i), .mem_req_i(mem_req_i),
    .dmem_ready_i(dmem_ready_i), .flush_all_i(flush_all_i),
    .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_stall_o(id_ex_stall_o),
    .id_ex_flush_o(id_ex_flush_o), .ex_mem_stall_o(ex_mem_stall_o),
    .ex_mem_flush_o(ex_mem_flush_o), .mem_wb_flush_o(mem_wb_flush_o),
    .state_o(state_o), .timeout_err_o(timeout_err_o)
  );

  assign outs = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
                 id_ex_flush_o, ex_mem_stall_o, ex_mem_flush_o, mem_wb_flush_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0; ex_rd_addr_i = 5'd0;
    id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0; ex_mem_read_i = 1'b0;
    ex_branch_taken_i = 1'b0; mem_req_i = 1'b0; dmem_ready_i = 1'b1;
    flush_all_i = 1'b0;
  endtask

  // Leaves the bench one time unit after a rising edge, reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    mem_req_i = 1'b1; dmem_ready_i = 1'b0; ex_branch_taken_i = 1'b1; flush_all_i = 1'b1;
    #2;
    n_checks++;
    if (outs !== C_NONE) begin n_fail++; $display("FAIL reset_outs got=%b want=%b", outs, C_NONE); end
    n_checks++;
    if (state_o !== 2'b00) begin n_fail++; $display("FAIL reset_state got=%b want=00", state_o); end
    n_checks++;
    if (timeout_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b want=0", timeout_err_o); end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read_i = 1'b1; ex_rd_addr_i = 5'd5; id_uses_rs1_i = 1'b1; id_rs1_addr_i = 5'd5;
    #2;
    n_checks++;
    if (outs !== C_LU) begin n_fail++; $display("FAIL lu_rs1_outs got=%b want=%b", outs, C_LU); end
    next_cycle();
    n_checks++;
    if (state_o !== 2'b01) begin n_fail++; $display("FAIL lu_bubble_state got=%b want=01", state_o); end
    #1;
    n_checks++;
    if (outs !== C_NONE) begin n_fail++; $display("FAIL lu_masked_outs got=%b want=%b", outs, C_NONE); end
    next_cycle();
    n_checks++;
    if (state_o !== 2'b00) begin n_fail++; $display("FAIL lu_return_state got=%b want=00", state_o); end
    set_idle();
    ex_mem_read_i = 1'b1; ex_rd_addr_i = 5'd0; id_uses_rs1_i = 1'b1; id_rs1_addr_i = 5'd0;
    #2;
    n_checks++;
    if (outs !== C_NONE) begin n_fail++; $display("FAIL lu_x0_outs got=%b want=%b", outs, C_NONE); end
    next_cycle();
    n_checks++;
    if (state_o !== 2'b00) begin n_fail++; $display("FAIL lu_x0_state got=%b want=00", state_o); end
    set_idle();
    ex_mem_read_i = 1'b1; ex_rd_addr_i = 5'd7; id_uses_rs2_i = 1'b1; id_rs2_addr_i = 5'd7;
    id_rs1_addr_i = 5'd7;
    #2;
    n_checks++;
    if (outs !== C_LU) begin n_fail++; $display("FAIL lu_rs2_outs got=%b want=%b", outs, C_LU); end
    next_cycle();
    set_idle();
    next_cycle();
    ex_mem_read_i = 1'b1; ex_rd_addr_i = 5'd9; id_uses_rs1_i = 1'b0; id_rs1_addr_i = 5'd9;
    #2;
    n_checks++;
    if (outs !== C_NONE) begin n_fail++; $display("FAIL lu_unused_rs_outs got=%b want=%b", outs, C_NONE); end
    set_idle();
  endtask

  task automatic test_branch();
    do_reset();
    ex_mem_read_i = 1'b1; ex_rd_addr_i = 5'd5; id_uses_rs1_i = 1'b1; id_rs1_addr_i = 5'd5;
    ex_branch_taken_i = 1'b1;
    #2;
    n_checks++;
    if (outs !== C_BR) begin n_fail++; $display("FAIL branch_outs got=%b want=%b", outs, C_BR); end
    next_cycle();
    n_checks++;
    if (state_o !== 2'b00) begin n_fail++; $display("FAIL branch_state got=%b want=00", state_o); end
    set_idle();
  endtask

  task automatic test_mem_wait();
    logic [1:0] want_st;
    do_reset();
    mem_req_i = 1'b1; dmem_ready_i = 1'b0; ex_branch_taken_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      want_st = (k == 1) ? 2'b00 : 2'b10;
      #2;
      n_checks++;
      if (outs !== C_FREEZ) begin n_fail++; $display("FAIL wait_outs_c%0d got=%b want=%b", k, outs, C_FREEZ); end
      n_checks++;
      if (state_o !== want_st) begin n_fail++; $display("FAIL wait_state_c%0d got=%b want=%b", k, state_o, want_st); end
      next_cycle();
    end
    dmem_ready_i = 1'b1;
    #2;
    n_checks++;
    if (outs !== C_BR) begin n_fail++; $display("FAIL wait_ready_outs got=%b want=%b", outs, C_BR); end
    n_checks++;
    if (state_o !== 2'b10) begin n_fail++; $display("FAIL wait_ready_state got=%b want=10", state_o); end
    next_cycle();
    set_idle();
    n_checks++;
    if (state_o !== 2'b00) begin n_fail++; $display("FAIL wait_after_state got=%b want=00", state_o); end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req_i = 1'b1; dmem_ready_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      n_checks++;
      if (timeout_err_o !== 1'(k >= MAX_WAIT)) begin
        n_fail++; $display("FAIL timeout_c%0d got=%b want=%b", k, timeout_err_o, 1'(k >= MAX_WAIT));
      end
    end
    n_checks++;
    if (outs !== C_FREEZ) begin n_fail++; $display("FAIL timeout_still_stall got=%b want=%b", outs, C_FREEZ); end
    dmem_ready_i = 1'b1;
    next_cycle();
    n_checks++;
    if (timeout_err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_after_ready got=%b want=1", timeout_err_o); end
    set_idle();
    flush_all_i = 1'b1;
    next_cycle();
    n_checks++;
    if (timeout_err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_after_flush got=%b want=1", timeout_err_o); end
    do_reset();
    n_checks++;
    if (timeout_err_o !== 1'b0) begin n_fail++; $display("FAIL timeout_after_reset got=%b want=0", timeout_err_o); end
  endtask

  task automatic test_trap();
    do_reset();
    mem_req_i = 1'b1; dmem_ready_i = 1'b0; flush_all_i = 1'b1;
    ex_mem_read_i = 1'b1; ex_rd_addr_i = 5'd3; id_uses_rs1_i = 1'b1; id_rs1_addr_i = 5'd3;
    #2;
    n_checks++;
    if (outs !== C_TRAP) begin n_fail++; $display("FAIL trap_run_outs got=%b want=%b", outs, C_TRAP); end
    next_cycle();
    n_checks++;
    if (state_o !== 2'b00) begin n_fail++; $display("FAIL trap_run_state got=%b want=00", state_o); end
    flush_all_i = 1'b0;
    next_cycle();
    flush_all_i = 1'b1;
    #2;
    n_checks++;
    if (outs !== C_TRAP) begin n_fail++; $display("FAIL trap_wait_outs got=%b want=%b", outs, C_TRAP); end
    next_cycle();
    n_checks++;
    if (state_o !== 2'b00) begin n_fail++; $display("FAIL trap_wait_state got=%b want=00", state_o); end
    set_idle();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_req_i = 1'b1; dmem_ready_i = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs !== C_NONE) begin n_fail++; $display("FAIL midrst_outs got=%b want=%b", outs, C_NONE); end
    n_checks++;
    if (state_o !== 2'b00) begin n_fail++; $display("FAIL midrst_state got=%b want=00", state_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    // A stale count of 2 would trip the timeout within these three busy cycles.
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      n_checks++;
      if (timeout_err_o !== 1'(k >= MAX_WAIT)) begin
        n_fail++; $display("FAIL midrst_cnt_c%0d got=%b want=%b", k, timeout_err_o, 1'(k >= MAX_WAIT));
      end
    end
    set_idle();
  endtask

  // Reference model: states 0 RUN, 1 bubble, 2 waiting; behaviour from the priority rules.
  function automatic bit m_lu_haz();
    bit hit1, hit2;
    hit1 = id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
    hit2 = id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);
    return ex_mem_read_i && (ex_rd_addr_i != 0) && (hit1 || hit2);
  endfunction

  function automatic logic [7:0] m_ctrl(int st);
    bit busy;
    busy = mem_req_i && !dmem_ready_i;
    if (flush_all_i) return C_TRAP;
    if (busy) return C_FREEZ;
    if (ex_branch_taken_i) return C_BR;
    if (st == 0 && m_lu_haz()) return C_LU;
    return C_NONE;
  endfunction

  task automatic test_random();
    int  m_st, m_cnt;
    bit  m_to, busy;
    logic [7:0] want;
    do_reset();
    m_st = 0; m_cnt = 0; m_to = 0;
    for (int c = 0; c < 3000; c++) begin
      ex_rd_addr_i      = 5'($urandom_range(0, 3));
      id_rs1_addr_i     = 5'($urandom_range(0, 3));
      id_rs2_addr_i     = 5'($urandom_range(0, 3));
      id_uses_rs1_i     = ($urandom_range(0, 3) != 0);
      id_uses_rs2_i     = ($urandom_range(0, 1) != 0);
      ex_mem_read_i     = ($urandom_range(0, 1) != 0);
      ex_branch_taken_i = ($urandom_range(0, 6) == 0);
      mem_req_i         = ($urandom_range(0, 2) == 0);
      dmem_ready_i      = (c < 1500) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 2) == 0);
      flush_all_i       = ($urandom_range(0, 19) == 0);
      #2;
      want = m_ctrl(m_st);
      n_checks++;
      if (outs !== want) begin n_fail++; $display("FAIL rand_outs c%0d got=%b want=%b", c, outs, want); end
      n_checks++;
      if (state_o !== 2'(m_st)) begin n_fail++; $display("FAIL rand_state c%0d got=%b want=%0d", c, state_o, m_st); end
      n_checks++;
      if (timeout_err_o !== m_to) begin n_fail++; $display("FAIL rand_timeout c%0d got=%b want=%b", c, timeout_err_o, m_to); end
      @(posedge clk);
      busy = mem_req_i && !dmem_ready_i;
      if (flush_all_i) begin
        m_st = 0; m_cnt = 0;
      end else if (busy) begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (m_cnt >= MAX_WAIT) m_to = 1;
        m_st = 2;
      end else begin
        m_cnt = 0;
        m_st = (!ex_branch_taken_i && m_st == 0 && m_lu_haz()) ? 1 : 0;
      end
      #1;
    end
    set_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_trap();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
